// File: rtl/secp256k1_pkg.sv
// -----------------------------------------------------------------------------
// secp256k1_pkg
// Shared constants and types for the secp256k1 field-arithmetic layer.
//   FIELD_W         : field element width in bits (256)
//   P_MOD           : field prime p = 2^256 - 2^32 - 977
//   mod_seq_state_t : IDLE/RUN/DONE state encoding used by the limb-serial
//                     sequencers (add now, mul/inv later)
// -----------------------------------------------------------------------------
package secp256k1_pkg;

   localparam int FIELD_W = 256;

   localparam logic [FIELD_W-1:0] P_MOD =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mod_seq_state_t;

endpackage

// File: rtl/limb_addsub.sv
// -----------------------------------------------------------------------------
// limb_addsub
// Combinational single-limb slice of the modular add (and optional subtract).
// Add mode : o_prim = a + b + carry           (carry chain -> o_carry)
//            o_corr = o_prim - m - borrow      (borrow chain -> o_borrow)
// Sub mode : o_prim = a - b - borrow          (borrow chain -> o_borrow)
//            o_corr = o_prim + m + carry       (carry chain -> o_carry)
// The subtract mode only exists when MOD_ADD_SUB_EN is defined; otherwise
// i_sub is ignored and only the add path is built.
// Ports:
//   i_a, i_b  : operand limbs
//   i_m       : modulus limb
//   i_carry   : carry from the previous limb
//   i_borrow  : borrow from the previous limb
//   i_sub     : 1 = subtract mode
//   o_prim    : primary result limb (sum or difference)
//   o_corr    : corrected result limb (minus p or plus p)
//   o_carry   : carry out of this limb
//   o_borrow  : borrow out of this limb
// -----------------------------------------------------------------------------
module limb_addsub #(
   parameter int LIMB_W = 64
) (
   input  logic [LIMB_W-1:0] i_a,
   input  logic [LIMB_W-1:0] i_b,
   input  logic [LIMB_W-1:0] i_m,
   input  logic              i_carry,
   input  logic              i_borrow,
   input  logic              i_sub,
   output logic [LIMB_W-1:0] o_prim,
   output logic [LIMB_W-1:0] o_corr,
   output logic              o_carry,
   output logic              o_borrow
);

   // Both chains are LIMB_W+1 bits: the MSB is the carry or borrow.
   logic [LIMB_W:0] w_add;
   logic [LIMB_W:0] w_dif;

`ifdef MOD_ADD_SUB_EN
   always_comb begin
      w_add  = '0;
      w_dif  = '0;
      o_prim = '0;
      o_corr = '0;
      if (i_sub) begin
         w_dif  = {1'b0, i_a} - {1'b0, i_b} - {{LIMB_W{1'b0}}, i_borrow};
         w_add  = {1'b0, w_dif[LIMB_W-1:0]} + {1'b0, i_m} + {{LIMB_W{1'b0}}, i_carry};
         o_prim = w_dif[LIMB_W-1:0];
         o_corr = w_add[LIMB_W-1:0];
      end else begin
         w_add  = {1'b0, i_a} + {1'b0, i_b} + {{LIMB_W{1'b0}}, i_carry};
         w_dif  = {1'b0, w_add[LIMB_W-1:0]} - {1'b0, i_m} - {{LIMB_W{1'b0}}, i_borrow};
         o_prim = w_add[LIMB_W-1:0];
         o_corr = w_dif[LIMB_W-1:0];
      end
   end
`else
   logic w_sub_unused;

   assign w_add        = {1'b0, i_a} + {1'b0, i_b} + {{LIMB_W{1'b0}}, i_carry};
   assign w_dif        = {1'b0, w_add[LIMB_W-1:0]} - {1'b0, i_m} - {{LIMB_W{1'b0}}, i_borrow};
   assign o_prim       = w_add[LIMB_W-1:0];
   assign o_corr       = w_dif[LIMB_W-1:0];
   assign w_sub_unused = i_sub;
`endif

   assign o_carry  = w_add[LIMB_W];
   assign o_borrow = w_dif[LIMB_W];

endmodule

// File: rtl/mod_add_seq.sv
// -----------------------------------------------------------------------------
// mod_add_seq
// Limb-serial modular adder over the secp256k1 prime: sum = (x + y) mod p,
// one LIMB_W-bit limb per cycle, LSB limb first. Both x+y and x+y-p are built
// in parallel; the last limb's carry/borrow picks one of them.
// Optional macro MOD_ADD_SUB_EN: when defined, sub=1 at accept computes
// (x - y) mod p with the same latency; when undefined, sub is ignored.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   in_valid  : operands valid
//   in_ready  : block idle, can accept operands
//   x, y      : 256-bit operands, expected < p
//   sub       : operation select, sampled at accept
//   out_valid : sum valid (held until out_ready)
//   out_ready : consumer accepts sum
//   sum       : 256-bit result
// Latency: out_valid rises N_LIMBS edges after the accept edge.
// -----------------------------------------------------------------------------
module mod_add_seq
   import secp256k1_pkg::*;
#(
   parameter int LIMB_W = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [FIELD_W-1:0] x,
   input  logic [FIELD_W-1:0] y,
   input  logic               sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [FIELD_W-1:0] sum
);

   localparam int N_LIMBS = FIELD_W / LIMB_W;
   localparam int CNT_W   = (N_LIMBS > 1) ? $clog2(N_LIMBS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_LIMBS - 1);

   mod_seq_state_t     r_state;
   logic [FIELD_W-1:0] r_x;
   logic [FIELD_W-1:0] r_y;
   logic [FIELD_W-1:0] r_p;
   logic [FIELD_W-1:0] r_sum;
   logic               r_carry;
   logic               r_borrow;
   logic [CNT_W-1:0]   r_cnt;

   logic [LIMB_W-1:0]  w_prim;
   logic [LIMB_W-1:0]  w_corr;
   logic               w_carry;
   logic               w_borrow;
   logic               w_last;
   logic               w_use_corr;
   logic               w_sub_mode;
   logic [FIELD_W-1:0] w_prim_full;
   logic [FIELD_W-1:0] w_corr_full;

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign sum       = r_sum;
   assign w_last    = (r_cnt == LAST_CNT);

   limb_addsub #(
      .LIMB_W (LIMB_W)
   ) u_limb (
      .i_a      (r_x[LIMB_W-1:0]),
      .i_b      (r_y[LIMB_W-1:0]),
      .i_m      (r_p[LIMB_W-1:0]),
      .i_carry  (r_carry),
      .i_borrow (r_borrow),
      .i_sub    (w_sub_mode),
      .o_prim   (w_prim),
      .o_corr   (w_corr),
      .o_carry  (w_carry),
      .o_borrow (w_borrow)
   );

`ifdef MOD_ADD_SUB_EN
   logic r_sub;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sub <= 1'b0;
      end else if (in_valid && in_ready) begin
         r_sub <= sub;
      end
   end

   assign w_sub_mode = r_sub;
   // Subtract: a final borrow means x < y, so the add-back (x - y + p) is right.
   // Add: a carry out of 256 bits or no borrow from s - p means s >= p.
   assign w_use_corr = r_sub ? w_borrow : (w_carry | ~w_borrow);
`else
   logic w_sub_unused;

   assign w_sub_unused = sub;
   assign w_sub_mode   = 1'b0;
   // A carry out of 256 bits or no borrow from s - p means s >= p.
   assign w_use_corr   = w_carry | ~w_borrow;
`endif

   // Completed lower limbs live in shift registers; the current limb is
   // appended on top so the full word is available combinationally on the
   // last limb without an extra cycle.
   generate
      if (N_LIMBS > 1) begin : g_multi
         logic [FIELD_W-LIMB_W-1:0] r_prim_lo;
         logic [FIELD_W-LIMB_W-1:0] r_corr_lo;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_prim_lo <= '0;
               r_corr_lo <= '0;
            end else if (r_state == RUN) begin
               r_prim_lo <= w_prim_full[FIELD_W-1:LIMB_W];
               r_corr_lo <= w_corr_full[FIELD_W-1:LIMB_W];
            end
         end

         assign w_prim_full = {w_prim, r_prim_lo};
         assign w_corr_full = {w_corr, r_corr_lo};
      end else begin : g_single
         assign w_prim_full = w_prim;
         assign w_corr_full = w_corr;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_x      <= '0;
         r_y      <= '0;
         r_p      <= '0;
         r_sum    <= '0;
         r_carry  <= 1'b0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_x      <= x;
                  r_y      <= y;
                  r_p      <= P_MOD;
                  r_carry  <= 1'b0;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               r_x      <= r_x >> LIMB_W;
               r_y      <= r_y >> LIMB_W;
               r_p      <= r_p >> LIMB_W;
               r_carry  <= w_carry;
               r_borrow <= w_borrow;
               if (w_last) begin
                  r_sum   <= w_use_corr ? w_corr_full : w_prim_full;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               // sum is only written on the last RUN limb, so it is stable here.
               if (out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mod_add_seq.md
# mod_add_seq

Limb-serial modular adder over the secp256k1 field prime p = 2^256 − 2^32 − 977, computing (x + y) mod p for x, y < p. It is the additive counterpart of the combinational `mod_sub` block and trades latency for area: one LIMB_W-bit limb per cycle, behind valid/ready handshakes. It sits in the field-arithmetic layer feeding point add/double sequencers.

## Interface
- `LIMB_W`, default 64: limb width in bits. Legal values are 32, 64, 128 and 256. `N_LIMBS = 256/LIMB_W`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands valid.
- `in_ready` output 1: block can accept operands.
- `x` input 256: first operand; must be < p.
- `y` input 256: second operand; must be < p.
- `sub` input 1: operation select, sampled at accept. Used only with `MOD_ADD_SUB_EN`.
- `out_valid` output 1: `sum` valid.
- `out_ready` input 1: consumer accepts result.
- `sum` output 256: the result.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: latch x, y and `sub`; clear carry, borrow and the limb counter; go to RUN.
- **RUN** (one limb per cycle, LSB limb first)
  - `s_k = x_k + y_k + carry`.
  - `d_k = s_k[LIMB_W-1:0] − p_k − borrow`.
  - Store both `s_k` and `d_k` in shift registers; update carry and borrow.
- **Last limb** (counter = N_LIMBS−1)
  - The final carry and borrow are formed combinationally.
  - Select: if `carry_out | ~borrow_out`, result = d (that is, s − p); otherwise result = s.
  - Register `sum` and go to DONE.
- **DONE**
  - `out_valid` = 1; `sum` is held stable.
  - On `out_ready`: go to IDLE.
- Arithmetic widths:
  - The limb adder is LIMB_W+1 bits wide.
  - The subtract uses LIMB_W+1 bits, with borrow = MSB.
  - No intermediate value exceeds 257 bits in total.
- Operands ≥ p: the result is unspecified (not checked); it must still complete in the same cycle count.
- `in_valid` asserted outside IDLE is ignored. No queueing, and there is no back-to-back acceptance in the handshake cycle.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `sum` = 0, FSM = IDLE, and all internal registers = 0.
- Latency: `out_valid` rises N_LIMBS edges after the accept edge. That is 4 cycles at LIMB_W = 64 and 1 cycle at LIMB_W = 256.
- Handshake: the output handshake completes on the edge where `out_valid & out_ready`. `in_ready` returns to 1 on the following cycle.
- Throughput: one result per N_LIMBS + 2 cycles when `out_ready` is held high.
- Back-pressure: with `out_ready` low, the block stays in DONE indefinitely and `sum` must not change.
- Reset asserted mid-RUN or mid-DONE: all state clears immediately. The pending result is discarded, and no `out_valid` pulse occurs after release.

## Configuration
- `MOD_ADD_SUB_EN` defined:
  - When `sub` = 1 at accept, the block computes (x − y) mod p.
  - Each limb uses `x_k − y_k − borrow` with the add-back path `+ p_k + carry`.
  - Select: if the subtract borrowed, result = (x − y) + p; otherwise result = x − y.
  - Latency is identical to the add path.
- `MOD_ADD_SUB_EN` undefined: the `sub` port is present but ignored, the block always adds, and the subtract datapath is not synthesized.

## Structure
- Package `secp256k1_pkg` holds:
  - `FIELD_W` = 256;
  - the constant `P_MOD` = FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFE FFFFFC2F (hex);
  - the FSM state enum `mod_seq_state_t` {IDLE, RUN, DONE}, shared with future serial mul/inv blocks.
- One sub-module, `limb_addsub`:
  - inputs: a, b, m limbs, carry_in, borrow_in and the sub mode;
  - outputs: the primary limb, the corrected limb, carry_out and borrow_out;
  - purely combinational, instantiated once.

## Test plan
- Small operands: x = 2, y = 3 → `sum` = 5. `out_valid` rises exactly 4 cycles after accept (LIMB_W = 64).
- Wrap to zero: x = p−1, y = 1 → `sum` = 0.
- Carry out of 256 bits: x = y = p−1 → `sum` = p−2 (…FFFFFC2D).
- Back-pressure: x = A3F9…0F12 and y = 9A3F…6789 from the `mod_sub` bench, with `out_ready` low for 10 cycles.
  - `sum` stays equal to the golden (x+y) mod p.
  - `in_ready` stays 0; a second `in_valid` during that window is ignored.
- Reset mid-RUN: pulse `reset` low at cycle 2 of RUN.
  - `out_valid` never rises.
  - `in_ready` = 1 after release.
  - A fresh x = 1, y = 1 then returns 2.
- `MOD_ADD_SUB_EN` builds only: `sub` = 1 with x = 0, y = 1 → `sum` = p−1. `sub` = 1 with x = 5, y = 3 → `sum` = 2.
